// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus: instruction-memory req/ack port plus the decode valid/ready port.
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_ack, imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_ack, imem_rdata, inst_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: latches pc, fetches over req/ack, buffers the word
// for decode over valid/ready, and drives npc/wpc for sequential advance or redirect.
module fetch_sequencer #(
  parameter int RESET_HOLD = 1
) (
  input  logic                clk,
  input  logic                clrn,
  input  logic [31:0]         pc,
  output logic [31:0]         npc,
  output logic                wpc,
  input  logic                redirect,
  input  logic [31:0]         redirect_target,
  fetch_sequencer_if.master   bus
);

  typedef enum logic [1:0] {LOAD, REQ, HOLD, DRAIN} state_t;

  localparam int CW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  state_t      state;
  logic [CW-1:0] hold_cnt;
  logic        hold_done;
  logic        req_q;
  logic        valid_q;
  logic [31:0] addr_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        handshake;
  logic [31:0] target;

  assign target    = {redirect_target[31:2], 2'b00};
  // A redirect kills the buffered instruction, so it can never complete a handshake.
  assign handshake = valid_q && bus.inst_ready && !redirect;
  assign wpc       = clrn && (redirect || handshake);
  assign npc       = !clrn     ? 32'h0 :
                     redirect  ? target :
                     handshake ? pc + 32'd4 : pc;

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = addr_q;
  assign bus.inst_valid = valid_q && !redirect;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= LOAD;
      hold_cnt  <= '0;
      hold_done <= 1'b0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      addr_q    <= 32'h0;
      inst_q    <= 32'h0;
      inst_pc_q <= 32'h0;
    end else begin
      case (state)
        LOAD: begin
          addr_q <= pc;
          if (!hold_done && hold_cnt != CW'(RESET_HOLD - 1)) begin
            hold_cnt <= hold_cnt + 1'b1;
          end else if (!redirect) begin
            hold_done <= 1'b1;
            req_q     <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (bus.imem_ack) begin
            req_q <= 1'b0;
            if (redirect) begin
              state <= LOAD;
            end else begin
              inst_q    <= bus.imem_rdata;
              inst_pc_q <= addr_q;
              valid_q   <= 1'b1;
              state     <= HOLD;
            end
          end else if (redirect) begin
            state <= DRAIN;
          end
        end
        HOLD: begin
          if (redirect || bus.inst_ready) begin
            valid_q <= 1'b0;
            state   <= LOAD;
          end
        end
        DRAIN: begin
          // The request stays up until memory answers; its data is thrown away.
          if (bus.imem_ack) begin
            req_q <= 1'b0;
            state <= LOAD;
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer: a memory/decode driver feeds a scoreboard of
// expected instructions, and a negedge monitor checks against an architectural pc model.
module tb_fetch_sequencer;

  localparam int RESET_HOLD = 2;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        wpc;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic [31:0] pc_init = 32'h0;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_HOLD(RESET_HOLD)) dut (
    .clk             (clk),
    .clrn            (clrn),
    .pc              (pc),
    .npc             (npc),
    .wpc             (wpc),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) pc <= pc_init;
    else if (wpc) pc <= npc;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
  } inst_t;

  inst_t exp_q[$];
  int total = 0;
  int bad = 0;
  int hs_count = 0;
  bit wrap_seen = 1'b0;

  int redir_pct = 0;
  int notready_pct = 0;
  int max_delay = 0;

  bit outstanding = 1'b0;
  bit live = 1'b0;
  bit live_ack = 1'b0;
  int delay = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
  endfunction

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Memory and decode behaviour for one cycle; live acks enqueue the expected instruction.
  task automatic apply_stimulus();
    if (!clrn) begin
      outstanding = 1'b0;
      live = 1'b0;
      live_ack = 1'b0;
      redirect = 1'b0;
      bus.inst_ready = 1'b0;
      bus.imem_ack = 1'b1;
      bus.imem_rdata = $urandom;
      exp_q.delete();
      return;
    end
    if (bus.imem_req && !outstanding) begin
      outstanding = 1'b1;
      live = 1'b1;
      delay = $urandom_range(max_delay, 0);
    end
    redirect = ($urandom_range(99, 0) < redir_pct);
    redirect_target = $urandom;
    bus.inst_ready = ($urandom_range(99, 0) >= notready_pct);
    live_ack = 1'b0;
    if (redirect) begin
      live = 1'b0;
      exp_q.delete();
    end
    if (outstanding) begin
      if (delay == 0) begin
        bus.imem_ack = 1'b1;
        bus.imem_rdata = mem_word(bus.imem_addr);
        if (live) begin
          exp_q.push_back('{addr: bus.imem_addr, word: mem_word(bus.imem_addr)});
          live_ack = 1'b1;
        end
        outstanding = 1'b0;
      end else begin
        delay--;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = $urandom;
      end
    end else begin
      bus.imem_ack = ($urandom_range(99, 0) < 20);
      bus.imem_rdata = $urandom;
    end
  endtask

  initial begin
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.inst_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      apply_stimulus();
    end
  end

  logic [31:0] model_pc = 32'h0;
  logic        prev_req = 1'b0, prev_ack = 1'b0, prev_valid = 1'b0, prev_hs = 1'b0;
  logic [31:0] prev_addr = 32'h0, prev_inst = 32'h0, prev_inst_pc = 32'h0;
  logic        hs_d1 = 1'b0, hs_d2 = 1'b0, redir_d1 = 1'b0, live_ack_d = 1'b0;

  always @(negedge clk) begin
    logic  hs;
    inst_t e;
    if (!clrn) begin
      check_bit("rst_req", bus.imem_req, 1'b0);
      check_bit("rst_valid", bus.inst_valid, 1'b0);
      check_bit("rst_wpc", wpc, 1'b0);
      check_word("rst_npc", npc, 32'h0);
      check_word("rst_addr", bus.imem_addr, 32'h0);
      check_word("rst_inst", bus.inst, 32'h0);
      check_word("rst_inst_pc", bus.inst_pc, 32'h0);
      model_pc = pc_init;
      exp_q.delete();
      {prev_req, prev_ack, prev_valid, prev_hs} = 4'b0;
      {hs_d1, hs_d2, redir_d1, live_ack_d} = 4'b0;
    end else begin
      hs = bus.inst_valid && bus.inst_ready && !redirect;
      if (prev_req && !prev_ack) begin
        check_bit("req_held", bus.imem_req, 1'b1);
        check_word("addr_held", bus.imem_addr, prev_addr);
      end else if (bus.imem_req && !prev_req) begin
        check_word("req_addr", bus.imem_addr, model_pc);
      end
      if (live_ack_d && !redirect) check_bit("valid_latency", bus.inst_valid, 1'b1);
      if (hs_d1) check_bit("req_gap1", bus.imem_req, 1'b0);
      if (hs_d2 && !redir_d1) check_bit("req_gap2", bus.imem_req, 1'b1);
      if (prev_valid && !prev_hs && !redirect) begin
        check_bit("valid_held", bus.inst_valid, 1'b1);
        check_word("inst_stable", bus.inst, prev_inst);
        check_word("inst_pc_stable", bus.inst_pc, prev_inst_pc);
      end
      if (redirect) begin
        check_bit("redir_valid", bus.inst_valid, 1'b0);
        check_bit("redir_wpc", wpc, 1'b1);
        check_word("redir_npc", npc, {redirect_target[31:2], 2'b00});
      end else if (hs) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_inst: got inst_pc %h expected none queued at %0t",
                   bus.inst_pc, $time);
        end else begin
          e = exp_q.pop_front();
          check_word("inst_word", bus.inst, e.word);
          check_word("inst_addr", bus.inst_pc, e.addr);
        end
        check_word("consume_pc", bus.inst_pc, model_pc);
        check_bit("seq_wpc", wpc, 1'b1);
        check_word("seq_npc", npc, model_pc + 32'd4);
      end else begin
        check_bit("idle_wpc", wpc, 1'b0);
        check_word("idle_npc", npc, model_pc);
      end
      check_word("pc_reg", pc, model_pc);

      prev_req = bus.imem_req;
      prev_ack = bus.imem_ack;
      prev_addr = bus.imem_addr;
      prev_valid = bus.inst_valid;
      prev_inst = bus.inst;
      prev_inst_pc = bus.inst_pc;
      prev_hs = hs;
      hs_d2 = hs_d1;
      hs_d1 = hs;
      redir_d1 = redirect;
      live_ack_d = live_ack;
      if (redirect) begin
        model_pc = {redirect_target[31:2], 2'b00};
      end else if (hs) begin
        if (model_pc == 32'hFFFF_FFFC) wrap_seen = 1'b1;
        model_pc = model_pc + 32'd4;
        hs_count++;
      end
    end
  end

  task automatic reset_and_release();
    int n;
    @(posedge clk);
    #3 clrn = 1'b0;
    repeat (3) @(posedge clk);
    #3 clrn = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.imem_req) break;
      n++;
    end
    check_word("reset_hold", 32'(n), 32'(RESET_HOLD));
  endtask

  initial begin
    int waited;
    $display("[TB] start");
    redir_pct = 0; notready_pct = 0; max_delay = 0;
    pc_init = 32'h0;
    reset_and_release();
    repeat (60) @(posedge clk);

    redir_pct = 8; notready_pct = 40; max_delay = 4;
    repeat (700) @(posedge clk);

    redir_pct = 0; notready_pct = 0; max_delay = 1;
    pc_init = 32'hFFFF_FFF4;
    reset_and_release();
    repeat (40) @(posedge clk);
    check_bit("wrap_seen", wrap_seen, 1'b1);

    waited = 0;
    do begin
      @(posedge clk);
      #3;
      waited++;
    end while (!bus.imem_req && waited < 30);
    check_bit("req_before_reset", bus.imem_req, 1'b1);
    clrn = 1'b0;
    #1;
    check_bit("abort_req", bus.imem_req, 1'b0);
    check_bit("abort_valid", bus.inst_valid, 1'b0);
    check_bit("abort_wpc", wpc, 1'b0);
    check_word("abort_npc", npc, 32'h0);
    repeat (2) @(posedge clk);
    #3 clrn = 1'b1;

    redir_pct = 0; notready_pct = 20; max_delay = 2;
    repeat (40) @(posedge clk);
    notready_pct = 0;
    waited = 0;
    while ((exp_q.size() != 0 || bus.imem_req || bus.inst_valid) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check_word("drain_left", 32'(exp_q.size()), 32'h0);
    check_bit("enough_fetches", hs_count >= 30, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
